pwm_dac: RTL and testbench
==========================

# pwm_dac

Audio PWM DAC for the `pwm_clk` domain. It buffers unsigned PCM samples in a small FIFO and loads one sample per PWM period into a duty register. Its output drives `pwm_out`, which the top level registers into the `AUD_PWM` IOB flop. Upstream, the sample producer writes through a valid/ready handshake; a clock-crossing FIFO is assumed to sit in front of this block if the producer runs on `cpu_clk`.

## Interface
- `CODE_WIDTH`, default 10: sample width. The PWM period is 2^CODE_WIDTH clocks.
- `FIFO_DEPTH`, default 8: sample buffer entries. Must be a power of 2 and ≥2.
- `clk` — in, 1: PWM clock.
- `rst` — in, 1: reset, asynchronous, active-high.
- `enable` — in, 1: run PWM and consume samples.
- `sample_data` — in, CODE_WIDTH: unsigned duty code.
- `sample_valid` — in, 1: producer has a sample.
- `sample_ready` — out, 1: FIFO can accept a sample.
- `pwm_out` — out, 1: PWM waveform.
- `underflow` — out, 1: one-cycle pulse when a period starts with the FIFO empty.
- `fifo_count` — out, $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Push:** a sample is written on any rising edge where `sample_valid && sample_ready`.
  - `sample_ready = (fifo_count != FIFO_DEPTH)` is combinational from registered state.
  - No push can happen while full.
- **Period counter:** `cnt` is CODE_WIDTH bits and `MAX = 2^CODE_WIDTH-1`.
  - While `enable` is 1, `cnt` increments each cycle and wraps from MAX to 0.
  - While `enable` is 0, `cnt` is held at MAX and `duty` is forced to 0.
- **Period boundary:** the edge where `enable=1` and `cnt==MAX`.
  - If the FIFO is non-empty, pop the head into `duty`.
  - If the FIFO is empty, `duty` keeps its value and `underflow` pulses high for the following cycle.
- **Output:** `pwm_out = (cnt < duty)`, evaluated from registers.
  - duty=0 gives a constant low output.
  - duty=MAX gives a high output for MAX of 2^CODE_WIDTH cycles.
- **Push and pop on the same edge:** both take effect, and `fifo_count` is unchanged.
- **Push into an empty FIFO on a boundary edge:** there is no bypass. The pop sees the FIFO as empty, so `underflow` fires. The sample is popped at the next boundary.
- **Deasserting `enable` mid-period:** on the next edge `cnt<=MAX` and `duty<=0`, so `pwm_out` goes low one cycle later. FIFO contents are retained.
- **Reasserting `enable`:** the first edge with `enable=1` is a boundary edge and pops a sample if one is available.
- **Reset (asynchronous, any time, including mid-period or mid-handshake):**
  - `cnt=MAX`, `duty=0`, FIFO empty (read and write pointers 0), `fifo_count=0`, `underflow=0`.
  - Resulting outputs: `pwm_out=0`, `sample_ready=1`.
- **Pointer arithmetic:** pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Occupancy is tracked by the separate counter, not by pointer difference.

## Timing
- **Handshake:** `sample_data` is captured on the edge where valid and ready are both high. The producer may hold valid high across multiple edges, and each such edge is a separate push.
- **Latency, sample to output:** a sample accepted into an empty, running FIFO first affects `pwm_out` in the cycle after the next boundary edge. Worst case is 2^CODE_WIDTH+1 cycles.
- **Latency, boundary to output:**
  - `duty` updates at the boundary edge, and `pwm_out` reflects it in the same cycle, where `cnt==0`.
  - `underflow` is asserted in that same cycle.
- **Period alignment:** the high phase of each period always begins at `cnt==0`. Periods are contiguous while `enable=1`.

## Structure
- No shared-package types are needed. `CODE_WIDTH` and `FIFO_DEPTH` stay as parameters.
- The existing codebase package gets a constant for the audio sample width (10), which z1top uses for instantiation.
- One sub-module, `sample_fifo`:
  - Synchronous single-clock FIFO with `WIDTH` and `DEPTH` parameters.
  - Ports: push, pop, full, empty, count, and dout showing the head.
- The top `pwm_dac` module holds the counter, the duty register, the boundary logic and the underflow pulse.

## Test plan
All scenarios use CODE_WIDTH=4 and FIFO_DEPTH=4, giving a 16-cycle period.
1. **Reset values:** assert `rst` mid-period with FIFO count 3 → outputs immediately `pwm_out=0`, `fifo_count=0`, `sample_ready=1`, `underflow=0`. After release with `enable=1` and an empty FIFO, `underflow` pulses at the first boundary.
2. **Duty sweep:** push 0, 1, 8, 15 with `enable=1` → successive periods show high-time of 0, 1, 8 and 15 cycles. Each high phase starts at `cnt==0`, and there is no `underflow` until the fifth boundary.
3. **Backpressure:** hold `sample_valid=1` with `enable=0` → exactly 4 pushes are accepted, then `sample_ready=0`. Raising `enable` pops one sample at the first edge, `sample_ready` returns to 1, and the next push is accepted.
4. **Simultaneous push and pop:** with count=2, push on the boundary edge → `fifo_count` stays 2 and data order is preserved.
5. **Underflow hold:** push 5, then supply no further samples → period 1 high-time is 5. Later periods keep high-time 5, and `underflow` pulses once per boundary.
6. **Enable drop:** deassert `enable` at `cnt==3` with duty 10 → `pwm_out` low from the following cycle. FIFO count is unchanged, and re-enabling pops the next sample on the first edge.

Source files
------------

// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the audio PWM DAC slice.
package pwm_dac_pkg;

    localparam int unsigned AUDIO_SAMPLE_WIDTH = 10;
    localparam int unsigned AUDIO_FIFO_DEPTH   = 8;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// Valid/ready sample stream from the PCM producer into the PWM DAC.
interface pwm_dac_if
    import pwm_dac_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_SAMPLE_WIDTH
);

    logic [WIDTH-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/pwm_dac_sample_fifo.sv
// Single-clock sample FIFO; occupancy kept in its own counter, head shown on dout.
module sample_fifo
    import pwm_dac_pkg::*;
#(
    parameter int unsigned WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int unsigned DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                din,
    input  logic                            pop,
    output logic                            full,
    output logic                            empty,
    output logic [count_width(DEPTH)-1:0]   count,
    output logic [WIDTH-1:0]                dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_push) wr_ptr_nxt = wr_ptr + AW'(1);
        if (do_pop)  rd_ptr_nxt = rd_ptr + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pwm_dac.sv
// Audio PWM DAC: buffers PCM codes and loads one into the duty register per PWM period.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int unsigned FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    pwm_dac_if.slave                             smp,
    output logic                                 pwm_out,
    output logic                                 underflow,
    output logic [count_width(FIFO_DEPTH)-1:0]   fifo_count
);

    localparam logic [CODE_WIDTH-1:0] MAX = '1;

    logic [CODE_WIDTH-1:0] cnt, cnt_nxt;
    logic [CODE_WIDTH-1:0] duty, duty_nxt;
    logic [CODE_WIDTH-1:0] head;
    logic                  underflow_nxt;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, boundary;

    assign smp.sample_ready = !fifo_full;
    assign push             = smp.sample_valid && !fifo_full;
    assign boundary         = enable && (cnt == MAX);
    assign pop              = boundary && !fifo_empty;
    assign pwm_out          = (cnt < duty);

    sample_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (CODE_WIDTH'(smp.sample_data)),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (head)
    );

    // Disabled: park the counter at MAX so the first enabled edge is a boundary.
    always_comb begin
        cnt_nxt       = cnt + CODE_WIDTH'(1);
        duty_nxt      = duty;
        underflow_nxt = boundary && fifo_empty;
        if (!enable) begin
            cnt_nxt  = MAX;
            duty_nxt = '0;
        end else if (pop) begin
            duty_nxt = head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= MAX;
            duty      <= '0;
            underflow <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            duty      <= duty_nxt;
            underflow <= underflow_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed self-checking bench for pwm_dac with a 4-bit code and a 4-entry FIFO.
module tb_pwm_dac;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       pwm_out;
    logic       underflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] pat;
    int          uf_n;
    logic        uf0;
    logic [2:0]  cnt1;

    pwm_dac_if #(.WIDTH(4)) smp ();

    pwm_dac #(
        .CODE_WIDTH (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .smp        (smp),
        .pwm_out    (pwm_out),
        .underflow  (underflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full 16-cycle period starting with a boundary edge; pat[i] is pwm_out at cnt==i.
    task automatic run_period(input bit push_first, input logic [3:0] d,
                              output logic [15:0] p, output int ufs,
                              output logic uf_first, output logic [2:0] cnt_first);
        smp.sample_valid = push_first;
        smp.sample_data  = d;
        ufs = 0;
        p   = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) begin
                smp.sample_valid = 1'b0;
                uf_first  = underflow;
                cnt_first = fifo_count;
            end
            p[i] = pwm_out;
            if (underflow === 1'b1) ufs++;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        smp.sample_valid = 1'b0; smp.sample_data = '0;
        tick(); tick();
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_ready", 32'(smp.sample_ready), 1);
        chk("rst_count", 32'(fifo_count), 0);
        rst = 1'b0;

        // Fill while disabled, then run into a period with three samples left.
        smp.sample_valid = 1'b1; smp.sample_data = 4'd7;
        repeat (4) tick();
        smp.sample_valid = 1'b0;
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_ready", 32'(smp.sample_ready), 0);
        enable = 1'b1;
        tick();
        chk("first_pop_count", 32'(fifo_count), 3);
        chk("first_pop_pwm", 32'(pwm_out), 1);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_pwm", 32'(pwm_out), 0);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_ready", 32'(smp.sample_ready), 1);
        chk("midrst_uf", 32'(underflow), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_uf", 32'(underflow), 1);
        chk("post_rst_pwm", 32'(pwm_out), 0);
        tick();
        chk("post_rst_uf_end", 32'(underflow), 0);

        // Duty sweep 0, 1, 8, 15.
        enable = 1'b0;
        tick();
        smp.sample_valid = 1'b1;
        smp.sample_data = 4'd0;  tick();
        smp.sample_data = 4'd1;  tick();
        smp.sample_data = 4'd8;  tick();
        smp.sample_data = 4'd15; tick();
        smp.sample_valid = 1'b0;
        chk("sweep_fill", 32'(fifo_count), 4);
        enable = 1'b1;
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("sweep0_pat", 32'(pat), 32'h0000);
        chk("sweep0_uf", 32'(uf_n), 0);
        chk("sweep0_count", 32'(cnt1), 3);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("sweep1_pat", 32'(pat), 32'h0001);
        chk("sweep1_uf", 32'(uf_n), 0);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("sweep8_pat", 32'(pat), 32'h00FF);
        chk("sweep8_uf", 32'(uf_n), 0);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("sweep15_pat", 32'(pat), 32'h7FFF);
        chk("sweep15_uf", 32'(uf_n), 0);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("sweep5th_uf0", 32'(uf0), 1);
        chk("sweep5th_pat", 32'(pat), 32'h7FFF);

        // Push 5 on a boundary edge into an empty FIFO: no bypass.
        run_period(1'b1, 4'd5, pat, uf_n, uf0, cnt1);
        chk("nobypass_uf0", 32'(uf0), 1);
        chk("nobypass_pat", 32'(pat), 32'h7FFF);
        chk("nobypass_count", 32'(cnt1), 1);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("uf_hold_p1_pat", 32'(pat), 32'h001F);
        chk("uf_hold_p1_uf", 32'(uf_n), 0);
        chk("uf_hold_p1_count", 32'(cnt1), 0);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("uf_hold_p2_pat", 32'(pat), 32'h001F);
        chk("uf_hold_p2_uf", 32'(uf_n), 1);
        chk("uf_hold_p2_uf0", 32'(uf0), 1);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("uf_hold_p3_pat", 32'(pat), 32'h001F);
        chk("uf_hold_p3_uf", 32'(uf_n), 1);

        // Load two samples mid-period, then push on the boundary edge.
        tick();
        smp.sample_valid = 1'b1; smp.sample_data = 4'd3;  tick();
        smp.sample_data = 4'd12; tick();
        smp.sample_valid = 1'b0;
        repeat (13) tick();
        chk("simul_pre_count", 32'(fifo_count), 2);
        run_period(1'b1, 4'd9, pat, uf_n, uf0, cnt1);
        chk("simul_count", 32'(cnt1), 2);
        chk("simul_pat3", 32'(pat), 32'h0007);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("order_pat12", 32'(pat), 32'h0FFF);
        chk("order_count", 32'(cnt1), 1);
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("order_pat9", 32'(pat), 32'h01FF);
        chk("order_empty", 32'(cnt1), 0);

        // Backpressure with enable low: exactly four accepted.
        enable = 1'b0;
        tick();
        smp.sample_valid = 1'b1;
        smp.sample_data = 4'd10; tick();
        smp.sample_data = 4'd6;  tick(); tick(); tick();
        chk("bp_count", 32'(fifo_count), 4);
        chk("bp_ready", 32'(smp.sample_ready), 0);
        smp.sample_data = 4'd1;  tick(); tick();
        chk("bp_hold_count", 32'(fifo_count), 4);
        smp.sample_data = 4'd13;
        enable = 1'b1;
        tick();
        chk("bp_pop_count", 32'(fifo_count), 3);
        chk("bp_pop_ready", 32'(smp.sample_ready), 1);
        chk("bp_pop_pwm", 32'(pwm_out), 1);
        tick();
        smp.sample_valid = 1'b0;
        chk("bp_next_push", 32'(fifo_count), 4);

        // Drop enable at cnt==3 with duty 10.
        tick(); tick();
        chk("drop_pre_pwm", 32'(pwm_out), 1);
        enable = 1'b0;
        tick();
        chk("drop_pwm", 32'(pwm_out), 0);
        chk("drop_count", 32'(fifo_count), 4);
        repeat (3) tick();
        chk("drop_hold_pwm", 32'(pwm_out), 0);
        enable = 1'b1;
        run_period(1'b0, 4'd0, pat, uf_n, uf0, cnt1);
        chk("reen_pat", 32'(pat), 32'h003F);
        chk("reen_count", 32'(cnt1), 3);
        chk("reen_uf", 32'(uf_n), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
